unidad_control: RTL
===================

// Module: unidad_control
// PURPOSE
//  Sequencer directly upstream of unidad_procesadora: fetches 16-bit instructions and emits its
//  16-bit control word. Sequences register-file I/O via valid/ready handshakes, latches datapath
//  flags after ALU ops and resolves conditional branches on them. One instruction per FETCH+EXEC.
// PARAMETERS
//  PC_W  4  program counter / instr_addr width (1..8); PC wraps modulo 2**PC_W
// PORTS
//  clk          in   1     single clock, rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  start        in   1     leave IDLE/HALT; PC restarts at 0
//  instr_addr   out  PC_W  fetch address (=pc)
//  fetch_req    out  1     high throughout FETCH
//  instr        in   16    instruction, sampled when fetch_req&instr_valid
//  instr_valid  in   1     instruction-memory response
//  flags        in   4     datapath {V,N,Z,C}, combinational from current control word
//  control      out  16    {A[15:14],B[13:12],dest[11:10],we[9],MB[8],alu[7:4],sh[3:2],MF[1],MD[0]}
//  in_valid     in   1     datain holds a value for LOADIN
//  in_ready     out  1     datain consumed this cycle
//  out_valid    out  1     dataout holds the OUT register value
//  out_ready    in   1     consumer accepts dataout
//  flags_q      out  4     latched flags of the last ALU op
//  halted       out  1     in HALT
//  illegal      out  1     one-cycle pulse: undefined opcode executed
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, pc=0, ir=0, flags_q=0; control=16'h0000;
//   fetch_req, in_ready, out_valid, halted, illegal = 0. Abandons any pending handshake.
//  control=16'h0000 in every state/cycle not listed below, so the datapath never writes.
//  FSM: IDLE -start-> FETCH; FETCH -instr_valid-> EXEC (ir<=instr); EXEC -> FETCH|WAIT_IN|WAIT_OUT|HALT;
//   WAIT_IN -in_valid-> FETCH; WAIT_OUT -out_ready-> FETCH; HALT -start-> FETCH, pc=0.
//   start ignored outside IDLE/HALT.
//  FETCH: fetch_req=1, instr_addr=pc; holds any number of cycles. instr_valid in the first cycle
//   gives 2 cycles/instruction.
//  Instruction: op=ir[15:12], d=ir[11:10], a=ir[9:8], b=ir[7:6], alu=ir[5:2], sh=ir[1:0],
//   tgt=ir[PC_W-1:0], mask=ir[11:8].
//  EXEC, one cycle. pc<=pc+1 (wrapping) unless stated:
//   0x0 NOP   control=0
//   0x1 ALU   {a,b,d,we=1,MB=0,alu,sh=00,MF=0,MD=0}; flags_q<=flags at the end of this cycle
//   0x2 SHF   {00,b,d,we=1,MB=0,0000,sh,MF=1,MD=0}; flags_q unchanged
//   0x3 LDIN  enter WAIT_IN; control=0 this cycle
//   0x4 OUT   enter WAIT_OUT; control=0 this cycle
//   0x5 JMP   pc<=tgt
//   0x6 BRS   pc<=tgt if |(flags_q&mask), else pc+1
//   0x7 BRC   pc<=tgt if ~|(flags_q&mask), else pc+1
//   0xF HALT  pc unchanged; halted=1 from the next cycle
//   other     NOP behaviour plus illegal=1 for this cycle
//  WAIT_IN: control={00,00,d,we=in_valid,MB=0,0000,00,MF=0,MD=1}; in_ready=in_valid.
//   The write happens exactly once, on the edge where in_valid=1.
//  WAIT_OUT: control={00,a,12'b0001_0000_0000} (readout word, we=0); out_valid=1.
//   Leaves on the edge where out_ready=1. dataout must be stable while out_valid.
//  Only an ALU op updates flags_q. A branch immediately after an ALU op sees the new flags.
//  pc increments by 1 from 2**PC_W-1 to 0. Jumping to the own address is legal (spin).
// TESTING
//  1 rst_n=0 mid-WAIT_OUT with out_ready=0 -> control=0, out_valid=0, pc=0, state IDLE at once (async).
//  2 LDIN r1; in_valid low 3 cycles then high 1 -> exactly one cycle with control=16'h0601, in_ready=1.
//  3 ALU r2=r1-r1 (Z set) then BRS mask=0010 tgt=9 -> flags_q=x01x, next instr_addr=9.
//    Same with BRC -> instr_addr = branch pc+1.
//  4 OUT r2, out_ready low 5 cycles -> control=16'h2100 and out_valid held 6 cycles, then FETCH.
//  5 PC_W=4: NOP at addr 15 -> next fetch addr 0. Opcode 0xA -> illegal pulses 1 cycle, pc+1.
//  6 HALT -> halted=1, fetch_req=0, control=0; start=1 -> fetch from addr 0, flags_q retained.

Source files
------------

// File: rtl/unidad_control.sv
// Instruction sequencer for unidad_procesadora. It fetches one 16-bit instruction, executes it
// in a single cycle and emits the datapath control word. Register I/O uses valid/ready waits.
module unidad_control #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] instr_addr,
  output logic            fetch_req,
  input  logic [15:0]     instr,
  input  logic            instr_valid,
  input  logic [3:0]      flags,
  output logic [15:0]     control,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      flags_q,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT_IN, WAIT_OUT, HALT} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [15:0]     ir;

  logic [3:0]      op, alu, mask;
  logic [1:0]      d, a, b, sh;
  logic [PC_W-1:0] tgt;

  assign op   = ir[15:12];
  assign d    = ir[11:10];
  assign a    = ir[9:8];
  assign b    = ir[7:6];
  assign alu  = ir[5:2];
  assign sh   = ir[1:0];
  assign mask = ir[11:8];
  assign tgt  = ir[PC_W-1:0];

  assign instr_addr = pc;
  assign halted     = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      flags_q <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == FETCH && instr_valid) ir <= instr;
      // flags are combinational from the ALU control word driven during this EXEC cycle
      if (state == EXEC && op == 4'h1) flags_q <= flags;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    control   = 16'h0000;
    fetch_req = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    illegal   = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_nxt = FETCH;
          pc_nxt    = '0;
        end
      end
      FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = FETCH;
        pc_nxt    = pc + PC_W'(1);
        case (op)
          4'h0: ;
          4'h1: control = {a, b, d, 1'b1, 1'b0, alu, 2'b00, 1'b0, 1'b0};
          4'h2: control = {2'b00, b, d, 1'b1, 1'b0, 4'b0000, sh, 1'b1, 1'b0};
          4'h3: state_nxt = WAIT_IN;
          4'h4: state_nxt = WAIT_OUT;
          4'h5: pc_nxt = tgt;
          4'h6: if (|(flags_q & mask))  pc_nxt = tgt;
          4'h7: if (~|(flags_q & mask)) pc_nxt = tgt;
          4'hF: begin
            state_nxt = HALT;
            pc_nxt    = pc;
          end
          default: illegal = 1'b1;
        endcase
      end
      WAIT_IN: begin
        // write enable follows in_valid so the register is written exactly once
        control  = {4'b0000, d, in_valid, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1};
        in_ready = in_valid;
        if (in_valid) state_nxt = FETCH;
      end
      WAIT_OUT: begin
        control   = {2'b00, a, 12'h100};
        out_valid = 1'b1;
        if (out_ready) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
